// File: rtl/transmisor_mdio_pkg.sv
// Shared types and constants for the MDIO management transmitter.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CTRL,
    S_TA,
    S_DATA,
    S_DONE
  } mdio_state_e;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned PRE_BITS   = 32;
  localparam int unsigned BODY_BITS  = FRAME_BITS - PRE_BITS;
  localparam int unsigned CNT_W      = 6;

  // Field positions inside the 32-bit frame body
  localparam int unsigned ST_LSB    = 30;
  localparam int unsigned ST_W      = 2;
  localparam int unsigned OP_LSB    = 28;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned PHYAD_LSB = 23;
  localparam int unsigned PHYAD_W   = 5;
  localparam int unsigned REGAD_LSB = 18;
  localparam int unsigned REGAD_W   = 5;
  localparam int unsigned TA_LSB    = 16;
  localparam int unsigned TA_W      = 2;
  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned DATA_W    = 16;

  localparam logic [OP_W-1:0] OP_READ  = 2'b10;
  localparam logic [OP_W-1:0] OP_WRITE = 2'b01;

  // Only OP=10 releases the bus; every other opcode is handled as a write
  function automatic logic is_read_op(input logic [OP_W-1:0] op);
    return (op == OP_READ);
  endfunction

endpackage

// File: rtl/transmisor_mdio_if.sv
// Request/serial bundle between the management host, the transmitter and the PHY side.
interface transmisor_mdio_if;
  import mdio_pkg::*;

  logic                 mdio_start;
  logic [BODY_BITS-1:0] t_data;
  logic                 mdio_in;
  logic                 mdc;
  logic                 mdio_oe;
  logic                 mdio_out;
  logic [CNT_W-1:0]     contador;
  logic [DATA_W-1:0]    rd_data;
  logic                 data_rdy;
  logic                 busy;

  // The transmitter is the station-management master
  modport master (
    input  mdio_start, t_data, mdio_in,
    output mdc, mdio_oe, mdio_out, contador, rd_data, data_rdy, busy
  );

  // Host / PHY environment
  modport slave (
    output mdio_start, t_data, mdio_in,
    input  mdc, mdio_oe, mdio_out, contador, rd_data, data_rdy, busy
  );

endinterface

// File: rtl/transmisor_mdio_mdc_gen.sv
// MDC divider: low for MDC_HALF clk, high for MDC_HALF clk, idle low when disabled.
module mdc_gen #(
  parameter int unsigned MDC_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic mdc_rise_c,
  output logic mdc_fall_c
);

  localparam int unsigned PERIOD = 2 * MDC_HALF;
  localparam int unsigned DIV_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             mdc_q, mdc_d;

  // Next divider phase; restarting at 0 keeps the first bit's low phase full length
  always_comb begin
    div_d = '0;
    mdc_d = 1'b0;
    if (en) begin
      div_d = (div_q == DIV_W'(PERIOD - 1)) ? '0 : div_q + DIV_W'(1);
      mdc_d = (div_d >= DIV_W'(MDC_HALF));
    end
  end

  // Strobes announce the edge that the next clk will produce
  assign mdc_rise_c = en && (div_q == DIV_W'(MDC_HALF - 1));
  assign mdc_fall_c = en && (div_q == DIV_W'(PERIOD - 1));

  // Divider state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc = mdc_q;

endmodule

// File: rtl/transmisor_mdio.sv
// MDIO management transmitter: serializes preamble + frame body, samples read data.
module transmisor_mdio
  import mdio_pkg::*;
#(
  parameter int unsigned MDC_HALF = 2
) (
  input  logic               clk,
  input  logic               reset,
  transmisor_mdio_if.master  bus
);

  mdio_state_e           state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]      contador_q, contador_d;
  logic [DATA_W-1:0]     rd_sh_q, rd_sh_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  is_read_q, is_read_d;
  logic                  mdio_oe_q, mdio_oe_d;
  logic                  mdio_out_q, mdio_out_d;
  logic                  data_rdy_q, data_rdy_d;
  logic                  busy_q, busy_d;

  logic                  run_c;
  logic                  mdc_rise_c;
  logic                  mdc_fall_c;
  logic                  mdc_w;

  assign run_c = state_q inside {S_PRE, S_CTRL, S_TA, S_DATA};

  mdc_gen #(
    .MDC_HALF (MDC_HALF)
  ) u_mdc_gen (
    .clk        (clk),
    .rst_n      (reset),
    .en         (run_c),
    .mdc        (mdc_w),
    .mdc_rise_c (mdc_rise_c),
    .mdc_fall_c (mdc_fall_c)
  );

  // Next-state and registered-output logic; bit boundaries follow mdc_fall_c
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    contador_d = contador_q;
    rd_sh_d    = rd_sh_q;
    rd_data_d  = rd_data_q;
    is_read_d  = is_read_q;
    mdio_oe_d  = mdio_oe_q;
    mdio_out_d = mdio_out_q;
    data_rdy_d = 1'b0;
    busy_d     = busy_q;

    if ((state_q == S_DATA) && mdc_rise_c) begin
      rd_sh_d = {rd_sh_q[DATA_W-2:0], bus.mdio_in};
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.mdio_start) begin
          state_d    = S_PRE;
          frame_d    = {{PRE_BITS{1'b1}}, bus.t_data};
          contador_d = CNT_W'(FRAME_BITS - 1);
          is_read_d  = is_read_op(bus.t_data[OP_LSB +: OP_W]);
          busy_d     = 1'b1;
          mdio_oe_d  = 1'b1;
          mdio_out_d = 1'b1;
        end
      end

      S_PRE, S_CTRL, S_TA, S_DATA: begin
        if (mdc_fall_c) begin
          if (contador_q == '0) begin
            state_d    = S_DONE;
            mdio_oe_d  = 1'b0;
            mdio_out_d = 1'b0;
            if (is_read_q) begin
              rd_data_d  = rd_sh_q;
              data_rdy_d = 1'b1;
            end
          end else begin
            contador_d = contador_q - CNT_W'(1);
            frame_d    = {frame_q[FRAME_BITS-2:0], 1'b0};
            // Segment changes land exactly on each field's LSB position
            if (contador_q == CNT_W'(BODY_BITS)) begin
              state_d = S_CTRL;
            end else if (contador_q == CNT_W'(REGAD_LSB)) begin
              state_d = S_TA;
            end else if (contador_q == CNT_W'(TA_LSB)) begin
              state_d = S_DATA;
            end
            mdio_oe_d  = !(is_read_q && (state_d inside {S_TA, S_DATA}));
            mdio_out_d = mdio_oe_d && frame_d[FRAME_BITS-1];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      contador_q <= '0;
      rd_sh_q    <= '0;
      rd_data_q  <= '0;
      is_read_q  <= 1'b0;
      mdio_oe_q  <= 1'b0;
      mdio_out_q <= 1'b0;
      data_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      contador_q <= contador_d;
      rd_sh_q    <= rd_sh_d;
      rd_data_q  <= rd_data_d;
      is_read_q  <= is_read_d;
      mdio_oe_q  <= mdio_oe_d;
      mdio_out_q <= mdio_out_d;
      data_rdy_q <= data_rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mdc      = mdc_w;
  assign bus.mdio_oe  = mdio_oe_q;
  assign bus.mdio_out = mdio_out_q;
  assign bus.contador = contador_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.data_rdy = data_rdy_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/transmisor_mdio.md
# transmisor_mdio

MDIO management-side transmitter: the station-management master that serializes a 32-bit management frame onto MDIO and drives MDC. It sits directly upstream of the PHY-side `receptor` stage and feeds it `mdc`, `mdio_oe`, `mdio_out` and the bit countdown `contador`. For read frames it samples `mdio_in` from the PHY and returns 16 bits of read data.

## Interface
- `MDC_HALF`, default 2: clk cycles per MDC half-period. Minimum 1; MDC period = 2*MDC_HALF clk.
- `clk`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `mdio_start`  in  1: one-clk request pulse; accepted only while `busy`=0.
- `t_data`  in  32: frame body {ST[31:30], OP[29:28], PHYAD[27:23], REGAD[22:18], TA[17:16], DATA[15:0]}; captured on accept.
- `mdio_in`  in  1: serial data from the PHY, meaningful during read TA/DATA.
- `mdc`  out  1: management clock.
- `mdio_oe`  out  1: 1 = this block drives MDIO.
- `mdio_out`  out  1: serial data driven toward the PHY.
- `contador`  out  6: frame bits remaining after the current bit (63..0); 0 when idle.
- `rd_data`  out  16: last read data; held until the next read completes.
- `data_rdy`  out  1: one-clk pulse when a read frame completes.
- `busy`  out  1: frame in progress.

## Operation
- Reset values: `mdc`=0, `mdio_oe`=0, `mdio_out`=0, `contador`=0, `rd_data`=0, `data_rdy`=0, `busy`=0; FSM in IDLE. Reset mid-frame aborts immediately with no `data_rdy`.
- Frame = 32 preamble ones followed by the 32 bits of `t_data`, MSB first: 64 bits total.
- OP=2'b10 is a read; every other OP value is a write, with all 64 bits driven.
- FSM states:
  - IDLE → PRE on accept.
  - PRE: 32 bits of 1.
  - CTRL: 14 bits, ST/OP/PHYAD/REGAD.
  - TA: 2 bits.
  - DATA: 16 bits.
  - DONE: 1 clk, then IDLE.
- Write: `mdio_oe`=1 for all 64 bits. TA is driven from `t_data[17:16]`.
- Read: `mdio_oe`=1 through PRE and CTRL. `mdio_oe` is 0 from the start of the first TA bit to the end of DATA. `mdio_out`=0 while `mdio_oe`=0.
- Read sampling: `mdio_in` is shifted into a 16-bit register during DATA only. `rd_data` is updated and `data_rdy` pulses in DONE.
- `mdio_start` during `busy` is ignored, not queued. `t_data` changes during a frame have no effect.

## Timing
- Accept at clk edge N: at edge N+1, `busy`=1, state PRE, `mdio_oe`=1, `mdio_out`=1, `contador`=63, `mdc`=0.
- Each bit lasts 2*MDC_HALF clk: `mdc` low for MDC_HALF clk, then high for MDC_HALF clk.
- `mdio_out`, `mdio_oe` and `contador` change only at bit start, i.e. coincident with `mdc` falling or the first bit; they are stable across the `mdc` rising edge.
- `mdio_in` is sampled at the clk edge where `mdc` goes 0→1.
- Frame occupies 64*2*MDC_HALF clk. DONE follows the last bit's high phase.
- In DONE: `mdc`=0, `mdio_oe`=0, `contador`=0, `busy`=1, `data_rdy`=1 for reads only.
- In the next cycle `busy`=0, and a new `mdio_start` is accepted in that same cycle.
- Back-to-back turnaround: minimum 2 clk between the last bit and the next frame's first bit.
- `mdc` idles low. No MDC edges are generated while idle.

## Structure
- Package `mdio_pkg`:
  - FSM state enum.
  - Field positions/widths (ST, OP, PHYAD, REGAD, TA, DATA).
  - `OP_READ`=2'b10 and `OP_WRITE`=2'b01.
  - `PRE_BITS`=32 and `FRAME_BITS`=64.
- Sub-module `mdc_gen`:
  - Divider counter producing `mdc` plus one-clk `mdc_rise` and `mdc_fall` strobes.
  - Enabled only while `busy`.
- Top module holds the FSM, 64-bit shift register, bit counter and read shift register.

## Test plan
- Reset mid-PRE (assert `reset` low asynchronously between clk edges) → all outputs 0 immediately; no `data_rdy`; next `mdio_start` accepted normally.
- Write, MDC_HALF=2, `t_data`=32'h5196_4546:
  - `mdio_out` sampled at `mdc` rises = 32 ones then 0101_0001_1001_0110_0100_0101_0100_0110.
  - `mdio_oe`=1 throughout; `busy` high 257 clk; no `data_rdy`.
- Read, MDC_HALF=2, `t_data`=32'h6194_0000, PHY model drives 16'hBEEF during DATA:
  - `mdio_oe` falls at TA bit 1.
  - `rd_data`=16'hBEEF with one `data_rdy` pulse.
  - `contador` counts 63→0.
- `mdio_start` pulsed mid-frame with a different `t_data` → ignored; frame bits unchanged.
- Back-to-back: start asserted in the first idle cycle after DONE → second frame begins next clk; MDC_HALF=1 and MDC_HALF=3 give 2- and 6-clk bit periods.
- OP=2'b11 → treated as write: `mdio_oe`=1 all 64 bits; `rd_data` unchanged.
